context_transfer: RTL and testbench

CONTEXT_TRANSFER -- requirements
Module: context_transfer

---
 rtl/context_transfer.sv | 207 ++++++++++++++++++++
 tb/tb_context_transfer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/context_transfer.sv
// context_transfer
//   Moves a processor context (stack pointer, call-stack pointer, program
//   counter, ALU flags) between the register outputs and a single-port RAM.
//   SAVE writes the captured inputs as packed words; RESUME reads the words,
//   stages them in shadow registers and commits them on the edge into DONE.
//   Each RAM word takes two cycles: ACCESS_A (address set up) and ACCESS_B
//   (write strobe for SAVE, read sample for RESUME).
//
//   Optional feature macro: CONTEXT_TRANSFER_CHECKSUM_EN
//     Adds a third word (word0 ^ word1 ^ CHECK_SEED). RESUME only commits
//     when the stored checksum matches and flags error otherwise.
//
// Ports
//   clk, reset                    clock (rising edge), async active-high reset
//   start, mode                   transfer request, 0 = RESUME, 1 = SAVE
//   baseAddress                   RAM address of word 0
//   saveStackPointer/CallStackPointer/ProgramCounter/AluFlags  values to save
//   ramDataOut                    RAM read data
//   ramAddress, ramWrite, ramDataIn  RAM address, write strobe, write data
//   busy, done, error             status (error valid with done)
//   stackPointer, callStackPointer, programCounter, aluFlags  restored context
module context_transfer #(
  parameter int          ADDR_BITS  = 8,
  parameter int          DATA_BITS  = 16,
  parameter int          PC_BITS    = 9,
  parameter int          CSP_ADJUST = 2,
  parameter logic [15:0] CHECK_SEED = 16'hA5A5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_BITS-1:0] baseAddress,
  input  logic [ADDR_BITS-1:0] saveStackPointer,
  input  logic [ADDR_BITS-1:0] saveCallStackPointer,
  input  logic [PC_BITS-1:0]   saveProgramCounter,
  input  logic [3:0]           saveAluFlags,
  input  logic [DATA_BITS-1:0] ramDataOut,
  output logic [ADDR_BITS-1:0] ramAddress,
  output logic                 ramWrite,
  output logic [DATA_BITS-1:0] ramDataIn,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_BITS-1:0] stackPointer,
  output logic [ADDR_BITS-1:0] callStackPointer,
  output logic [PC_BITS-1:0]   programCounter,
  output logic [3:0]           aluFlags
);

`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
  localparam logic [1:0] LAST_INDEX = 2'd2;
`else
  localparam logic [1:0] LAST_INDEX = 2'd1;
`endif
  localparam logic [ADDR_BITS-1:0] ADJ  = ADDR_BITS'(CSP_ADJUST);
  localparam logic [DATA_BITS-1:0] SEED = DATA_BITS'(CHECK_SEED);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS_A, S_ACCESS_B, S_DONE} state_t;

  state_t               r_state;
  logic [1:0]           r_index;
  logic                 r_save;
  logic [ADDR_BITS-1:0] r_base;
  logic [ADDR_BITS-1:0] r_sp;
  logic [ADDR_BITS-1:0] r_csp;     // already biased by -CSP_ADJUST
  logic [PC_BITS-1:0]   r_pc;
  logic [3:0]           r_flags;
  logic [DATA_BITS-1:0] r_word0;   // RESUME shadow for word0
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
  logic [DATA_BITS-1:0] r_word1;   // RESUME shadow for word1
  logic                 r_error;
`endif

  logic [DATA_BITS-1:0] w_save_word0;
  logic [DATA_BITS-1:0] w_save_word1;
  logic [DATA_BITS-1:0] w_save_word2;
  logic [DATA_BITS-1:0] w_save_word;
  logic [DATA_BITS-1:0] w_load_word0;
  logic [DATA_BITS-1:0] w_load_word1;
  logic                 w_sum_ok;
  logic [ADDR_BITS-1:0] w_next_addr;
  logic                 w_unused_bits;

  // Packed SAVE words built from the captured values; unused bits are zero.
  always_comb begin
    w_save_word0 = '0;
    w_save_word0[2*ADDR_BITS-1:ADDR_BITS] = r_sp;
    w_save_word0[ADDR_BITS-1:0]           = r_csp;
    w_save_word1 = '0;
    w_save_word1[DATA_BITS-1 -: 4]        = r_flags;
    w_save_word1[PC_BITS-1:0]             = r_pc;
    w_save_word2 = w_save_word0 ^ w_save_word1 ^ SEED;
    case (r_index)
      2'd0:    w_save_word = w_save_word0;
      2'd1:    w_save_word = w_save_word1;
      default: w_save_word = w_save_word2;
    endcase
  end

  // Write data comes straight from held registers, so it is stable across A and B.
  assign ramDataIn = w_save_word;

  // The last word of a RESUME is consumed directly from the RAM on the edge into DONE.
  assign w_load_word0 = r_word0;
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
  assign w_load_word1 = r_word1;
  assign w_sum_ok     = (ramDataOut == (r_word0 ^ r_word1 ^ SEED));
  assign error        = r_error;
`else
  assign w_load_word1 = ramDataOut;
  assign w_sum_ok     = 1'b1;
  assign error        = 1'b0;
`endif

  assign w_next_addr   = r_base + ADDR_BITS'(r_index + 2'd1);
  // Padding bits of the context words carry no information.
  assign w_unused_bits = ^{1'b0, r_word0, ramDataOut};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_index          <= '0;
      r_save           <= 1'b0;
      r_base           <= '0;
      r_sp             <= '0;
      r_csp            <= '0;
      r_pc             <= '0;
      r_flags          <= '0;
      r_word0          <= '0;
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
      r_word1          <= '0;
      r_error          <= 1'b0;
`endif
      ramAddress       <= '0;
      ramWrite         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stackPointer     <= '0;
      callStackPointer <= '0;
      programCounter   <= '0;
      aluFlags         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ramWrite <= 1'b0;
          done     <= 1'b0;
          if (start) begin
            r_save     <= mode;
            r_base     <= baseAddress;
            r_sp       <= saveStackPointer;
            r_csp      <= saveCallStackPointer - ADJ;
            r_pc       <= saveProgramCounter;
            r_flags    <= saveAluFlags;
            r_index    <= 2'd0;
            ramAddress <= baseAddress;
            busy       <= 1'b1;
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
            r_error    <= 1'b0;
`endif
            r_state    <= S_ACCESS_A;
          end
        end
        S_ACCESS_A: begin
          ramWrite <= r_save;   // write strobe only during B
          r_state  <= S_ACCESS_B;
        end
        S_ACCESS_B: begin
          ramWrite <= 1'b0;
          if (!r_save) begin
            if (r_index == 2'd0) r_word0 <= ramDataOut;
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
            if (r_index == 2'd1) r_word1 <= ramDataOut;
`endif
          end
          if (r_index == LAST_INDEX) begin
            r_state    <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            ramAddress <= r_base;
            if (!r_save) begin
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
              r_error <= !w_sum_ok;
`endif
              if (w_sum_ok) begin
                stackPointer     <= w_load_word0[2*ADDR_BITS-1:ADDR_BITS];
                callStackPointer <= w_load_word0[ADDR_BITS-1:0] + ADJ;
                programCounter   <= w_load_word1[PC_BITS-1:0];
                aluFlags         <= w_load_word1[DATA_BITS-1 -: 4];
              end
            end
          end else begin
            r_index    <= r_index + 2'd1;
            ramAddress <= w_next_addr;
            r_state    <= S_ACCESS_A;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_context_transfer.sv
// Testbench for context_transfer: directed cases plus randomized SAVE/RESUME
// traffic checked against a word-level model of the context layout.
module tb_context_transfer;

`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
  localparam int NW = 3;
`else
  localparam int NW = 2;
`endif
  localparam logic [15:0] SEED = 16'hA5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  baseAddress = '0;
  logic [7:0]  saveStackPointer = '0;
  logic [7:0]  saveCallStackPointer = '0;
  logic [8:0]  saveProgramCounter = '0;
  logic [3:0]  saveAluFlags = '0;
  logic [15:0] ramDataOut;
  logic [7:0]  ramAddress;
  logic        ramWrite;
  logic [15:0] ramDataIn;
  logic        busy, done, error;
  logic [7:0]  stackPointer, callStackPointer;
  logic [8:0]  programCounter;
  logic [3:0]  aluFlags;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // RAM seen by the DUT, plus a bench-side poke port for preloading/corruption.
  logic [15:0] mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;

  // Reference model state.
  logic [15:0] ref_mem [256];
  logic [7:0]  exp_sp = '0, exp_csp = '0;
  logic [8:0]  exp_pc = '0;
  logic [3:0]  exp_flags = '0;
  logic        last_err;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWrite) mem[ramAddress] <= ramDataIn;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end
  assign ramDataOut = mem[ramAddress];

  context_transfer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .baseAddress(baseAddress),
    .saveStackPointer(saveStackPointer),
    .saveCallStackPointer(saveCallStackPointer),
    .saveProgramCounter(saveProgramCounter),
    .saveAluFlags(saveAluFlags),
    .ramDataOut(ramDataOut),
    .ramAddress(ramAddress), .ramWrite(ramWrite), .ramDataIn(ramDataIn),
    .busy(busy), .done(done), .error(error),
    .stackPointer(stackPointer), .callStackPointer(callStackPointer),
    .programCounter(programCounter), .aluFlags(aluFlags)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_sp"},    stackPointer,     exp_sp);
    check_eq({tag, "_csp"},   callStackPointer, exp_csp);
    check_eq({tag, "_pc"},    programCounter,   exp_pc);
    check_eq({tag, "_flags"}, aluFlags,         exp_flags);
  endtask

  // One complete transfer: drives start at edge 0, checks every cycle up to
  // two cycles past the expected done, then updates and checks the model.
  task automatic run_txn(input bit save_mode, input logic [7:0] base,
                         input logic [7:0] sp, input logic [7:0] csp,
                         input logic [8:0] pc, input logic [3:0] fl,
                         input bit pulse_busy);
    logic [15:0] w [3];
    logic [7:0]  a;
    int          done_cycle, done_count, j;
    logic        err_seen, exp_err;
    done_cycle = 0; done_count = 0; err_seen = 1'b0; exp_err = 1'b0;
    if (save_mode) begin
      w[0] = {sp, csp - 8'd2};
      w[1] = {fl, 3'b000, pc};
      w[2] = w[0] ^ w[1] ^ SEED;
    end else begin
      for (int i = 0; i < 3; i++) w[i] = ref_mem[8'(base + 8'(i))];
    end
    @(negedge clk);
    start = 1'b1; mode = save_mode; baseAddress = base;
    saveStackPointer = sp; saveCallStackPointer = csp;
    saveProgramCounter = pc; saveAluFlags = fl;
    for (int k = 1; k <= 2*NW + 2; k++) begin
      @(negedge clk);
      start = pulse_busy && (k == 2 || k == 2*NW + 1);
      if (k == 1) begin
        // Inputs are only sampled with start; scramble them afterwards.
        mode = 1'($urandom); baseAddress = 8'($urandom);
        saveStackPointer = 8'($urandom); saveCallStackPointer = 8'($urandom);
        saveProgramCounter = 9'($urandom); saveAluFlags = 4'($urandom);
      end
      if (k <= 2*NW) begin
        j = (k - 1) / 2;
        a = 8'(base + 8'(j));
        check_eq("addr", ramAddress, a);
        check_eq("ramwrite", ramWrite, save_mode && (k % 2 == 0));
        check_eq("busy", busy, 1'b1);
        if (save_mode && (k % 2 == 0)) check_eq("wdata", ramDataIn, w[j]);
      end
      if (done) begin
        done_count++;
        done_cycle = k;
        err_seen = error;
      end
    end
    start = 1'b0;
    check_eq("done_cycle", done_cycle, 2*NW + 1);
    check_eq("done_count", done_count, 1);
    check_eq("busy_idle", busy, 1'b0);
    check_eq("ramwrite_idle", ramWrite, 1'b0);
    check_eq("addr_idle", ramAddress, base);
    if (save_mode) begin
      for (int i = 0; i < NW; i++) begin
        a = 8'(base + 8'(i));
        ref_mem[a] = w[i];
        check_eq("ram_word", mem[a], ref_mem[a]);
      end
    end else begin
`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
      exp_err = (w[2] != (w[0] ^ w[1] ^ SEED));
`endif
      if (!exp_err) begin
        exp_sp    = w[0][15:8];
        exp_csp   = w[0][7:0] + 8'd2;
        exp_pc    = w[1][8:0];
        exp_flags = w[1][15:12];
      end
    end
    check_eq("error", err_seen, exp_err);
    check_outputs("ctx");
    last_err = err_seen;
    n_txn++;
    $display("txn %0d %s base=%02h done_cycle=%0d error=%0b sp=%02h csp=%02h pc=%03h flags=%h",
             n_txn, save_mode ? "SAVE  " : "RESUME", base, done_cycle, err_seen,
             stackPointer, callStackPointer, programCounter, aluFlags);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout sim_time=%0t limit=500000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  rsp, rcsp, rbase, last_save_base;
    logic [8:0]  rpc;
    logic [3:0]  rfl;
    bit          smode;
    int          cnt;

    // Preload RAM while held in reset.
    for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_ramwrite", ramWrite, 1'b0);
    check_eq("rst_addr", ramAddress, 8'h00);
    check_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Known-value RESUME.
    poke(8'h10, 16'h3C05);
    poke(8'h11, 16'h5123);
    poke(8'h12, 16'h3C05 ^ 16'h5123 ^ SEED);
    run_txn(1'b0, 8'h10, 8'h00, 8'h00, 9'h000, 4'h0, 1'b0);
    check_eq("k_sp", stackPointer, 8'h3C);
    check_eq("k_csp", callStackPointer, 8'h07);
    check_eq("k_pc", programCounter, 9'h123);
    check_eq("k_flags", aluFlags, 4'h5);

    // Known-value SAVE.
    run_txn(1'b1, 8'h20, 8'h40, 8'h12, 9'h0FF, 4'hA, 1'b0);
    check_eq("k_ram20", mem[8'h20], 16'h4010);
    check_eq("k_ram21", mem[8'h21], 16'hA0FF);
    check_eq("k_keep_sp", stackPointer, 8'h3C);

    // Address wrap with ignored start pulses while busy and in DONE.
    run_txn(1'b0, 8'hFF, 8'h00, 8'h00, 9'h000, 4'h0, 1'b1);

    // Reset in cycle 3 of a RESUME.
    run_txn(1'b0, 8'h10, 8'h00, 8'h00, 9'h000, 4'h0, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; baseAddress = 8'h10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_sp = '0; exp_csp = '0; exp_pc = '0; exp_flags = '0;
    check_outputs("async_rst");
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_addr", ramAddress, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check_eq("rst_no_done", cnt, 0);
    check_outputs("rst_no_commit");
    run_txn(1'b0, 8'h10, 8'h00, 8'h00, 9'h000, 4'h0, 1'b0);

    // SAVE then RESUME round trip.
    rsp = 8'($urandom); rcsp = 8'($urandom); rpc = 9'($urandom); rfl = 4'($urandom);
    run_txn(1'b1, 8'h40, rsp, rcsp, rpc, rfl, 1'b0);
    run_txn(1'b0, 8'h40, 8'h00, 8'h00, 9'h000, 4'h0, 1'b0);
    check_eq("rt_sp", stackPointer, rsp);
    check_eq("rt_csp", callStackPointer, rcsp);
    check_eq("rt_pc", programCounter, rpc);
    check_eq("rt_flags", aluFlags, rfl);
    check_eq("rt_error", last_err, 1'b0);

`ifdef CONTEXT_TRANSFER_CHECKSUM_EN
    // Corrupted checksum word: error with done, outputs kept.
    poke(8'h42, ref_mem[8'h42] ^ 16'h0001);
    run_txn(1'b0, 8'h40, 8'h00, 8'h00, 9'h000, 4'h0, 1'b0);
    check_eq("bad_error", last_err, 1'b1);
    check_eq("bad_keep_sp", stackPointer, rsp);
    check_eq("bad_keep_pc", programCounter, rpc);
`endif

    // Randomized traffic.
    last_save_base = 8'h40;
    for (int t = 0; t < 40; t++) begin
      smode = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rbase = 8'hFF;
        1:       rbase = last_save_base;
        default: rbase = 8'($urandom);
      endcase
      rsp = 8'($urandom); rcsp = 8'($urandom); rpc = 9'($urandom); rfl = 4'($urandom);
      if (!smode && $urandom_range(0, 3) == 0)
        poke(8'(rbase + 8'($urandom_range(0, NW - 1))), 16'($urandom));
      if (smode) last_save_base = rbase;
      run_txn(smode, rbase, rsp, rcsp, rpc, rfl, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
